// File: rtl/fp_mul_core.sv
// rtl/fp_mul_core.sv - sequential IEEE-754 single-precision multiplier core (shift-add, 1 bit/cycle)
// Optional rounding: define FPMUL_ROUND_EN for round-to-nearest-even, otherwise truncate.
module fp_mul_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] temp_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2,
        ST_PACK = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_result;
    logic               r_sign;
    logic               r_zero;
    logic [7:0]         r_exp1;
    logic [7:0]         r_exp2;
    logic [47:0]        r_mcand;
    logic [23:0]        r_mplier;
    logic [47:0]        r_acc;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_exp;
    logic [22:0]        r_mant;
`ifdef FPMUL_ROUND_EN
    logic               r_guard;
    logic               r_sticky;
    logic               w_round_inc;
    logic [23:0]        w_mant_rnd;
`endif

    logic               w_special;
    logic signed [9:0]  w_exp_sum;
    logic signed [9:0]  w_exp_adj;
    logic [22:0]        w_mant_out;
    logic [31:0]        w_pack;

    // Zero, denormal, Inf and NaN operands bypass the multiply entirely.
    assign w_special = (in1[30:23] == 8'h00) || (in1[30:23] == 8'hFF) ||
                       (in2[30:23] == 8'h00) || (in2[30:23] == 8'hFF);

    // Biased exponent sum; 10-bit signed so underflow shows as a non-positive value.
    assign w_exp_sum = $signed({2'b00, r_exp1} + {2'b00, r_exp2} - 10'd127);

    // Rounding, overflow/underflow saturation and final packing of the result word.
    always_comb begin
        w_exp_adj  = r_exp;
        w_mant_out = r_mant;
`ifdef FPMUL_ROUND_EN
        w_round_inc = r_guard & (r_sticky | r_mant[0]);
        w_mant_rnd  = {1'b0, r_mant} + {23'h0, w_round_inc};
        if (w_mant_rnd[23]) begin
            w_mant_out = 23'h0;
            w_exp_adj  = r_exp + 10'sd1;
        end else begin
            w_mant_out = w_mant_rnd[22:0];
        end
`endif
        if (r_zero) begin
            w_pack = {r_sign, 31'h0};
        end else if (w_exp_adj >= 10'sd255) begin
            w_pack = {r_sign, 8'hFF, 23'h0};
        end else if (w_exp_adj <= 10'sd0) begin
            w_pack = {r_sign, 31'h0};
        end else begin
            w_pack = {r_sign, w_exp_adj[7:0], w_mant_out};
        end
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'h0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_exp1   <= 8'h0;
            r_exp2   <= 8'h0;
            r_mcand  <= 48'h0;
            r_mplier <= 24'h0;
            r_acc    <= 48'h0;
            r_cnt    <= 5'd0;
            r_exp    <= 10'sd0;
            r_mant   <= 23'h0;
`ifdef FPMUL_ROUND_EN
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped on purpose.
                    if (start && !r_done) begin
                        r_sign   <= in1[31] ^ in2[31];
                        r_exp1   <= in1[30:23];
                        r_exp2   <= in2[30:23];
                        r_mcand  <= {24'h0, 1'b1, in1[22:0]};
                        r_mplier <= {1'b1, in2[22:0]};
                        r_acc    <= 48'h0;
                        r_cnt    <= 5'd0;
                        r_zero   <= w_special;
                        r_busy   <= 1'b1;
                        r_state  <= w_special ? ST_PACK : ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 48'h0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_acc[47]) begin
                        r_mant   <= r_acc[46:24];
                        r_exp    <= w_exp_sum + 10'sd1;
`ifdef FPMUL_ROUND_EN
                        r_guard  <= r_acc[23];
                        r_sticky <= |r_acc[22:0];
`endif
                    end else begin
                        r_mant   <= r_acc[45:23];
                        r_exp    <= w_exp_sum;
`ifdef FPMUL_ROUND_EN
                        r_guard  <= r_acc[22];
                        r_sticky <= |r_acc[21:0];
`endif
                    end
                    r_state <= ST_PACK;
                end
                ST_PACK: begin
                    r_result <= w_pack;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign temp_result = r_result;

endmodule

// File: tb/tb_fp_mul_core.sv
// tb/tb_fp_mul_core.sv - self-checking bench for fp_mul_core
module tb_fp_mul_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] temp_result;

    fp_mul_core dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .temp_result (temp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] exp_q [$];
    int          total;
    int          bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // mode 0: plain op; 1: extra start pulsed mid-operation; 2: start driven in the done cycle
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input int lat, input int mode, input string name);
        int          k;
        bit          got;
        bit          busy_bad;
        int          extra;
        logic [31:0] expv;
        @(negedge clk);
        start = 1'b1;
        in1   = a;
        in2   = b;
        exp_q.push_back(r);
        @(negedge clk);
        start = 1'b0;
        in1   = 32'h0;
        in2   = 32'h0;
        check({name, "_busy_after_start"}, {31'h0, busy}, 32'h1);
        got      = 1'b0;
        busy_bad = 1'b0;
        k        = 0;
        while (!got && k < 40) begin
            if (mode == 1 && k == 5) begin
                start = 1'b1;
                in1   = 32'h3F800000;
                in2   = 32'h3F800000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
            else if (!busy) busy_bad = 1'b1;
        end
        start = 1'b0;
        check({name, "_done_seen"}, {31'h0, got}, 32'h1);
        expv = exp_q.pop_front();
        if (got) begin
            check({name, "_result"}, temp_result, expv);
            check({name, "_latency"}, k, lat);
            check({name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
            check({name, "_busy_held"}, {31'h0, busy_bad}, 32'h0);
            if (mode == 2) begin
                start = 1'b1;
                in1   = 32'h3F800000;
                in2   = 32'h3F800000;
            end
            @(negedge clk);
            start = 1'b0;
            check({name, "_done_pulse"}, {31'h0, done}, 32'h0);
            if (mode == 2) check({name, "_start_at_done_ignored"}, {31'h0, busy}, 32'h0);
            if (mode == 1) begin
                extra = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (done) extra++;
                end
                check({name, "_no_second_done"}, extra, 0);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        in1   = 32'h0;
        in2   = 32'h0;

        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 26};
        vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 26};
        vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 26};
`ifdef FPMUL_ROUND_EN
        vecs[3]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 26};
`else
        vecs[3]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 26};
`endif
        vecs[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 26};
        vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 26};
        vecs[6]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 1};
        vecs[7]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 26};
        vecs[8]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 26};
        vecs[9]  = '{32'h7FC00000, 32'hBF800000, 32'h80000000, 1};
        vecs[10] = '{32'h80800000, 32'h00800000, 32'h80000000, 26};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", temp_result, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        do_op(32'h40000000, 32'h40400000, 32'h40C00000, 26, 1, "ghost_start");
        do_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 26, 2, "start_at_done");

        // Reset during MUL: temp_result is non-zero beforehand, so the clear is observable.
        @(negedge clk);
        start = 1'b1;
        in1   = 32'h40000000;
        in2   = 32'h40400000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_done", {31'h0, done}, 32'h0);
        check("midreset_result", temp_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h40000000, 32'h40400000, 32'h40C00000, 26, 0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
